johnson_phase_decoder: RTL

JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

---
 rtl/johnson_phase_decoder_pkg.sv | 38 +++
 rtl/johnson_code_lookup.sv | 29 ++
 rtl/johnson_phase_decoder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/johnson_phase_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : johnson_phase_decoder_pkg
// Description : Shared types and constants for the 5-stage Johnson (twisted
//               ring) phase decoder: FSM state encoding, phase count, the
//               legal-code table and small phase helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package johnson_phase_decoder_pkg;

    localparam int NUM_PHASES = 10;

    // Lock tracker states, explicit one-bit encoding.
    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } jpd_state_t;

    // Legal twisted-ring codes, indexed by phase number.
    localparam logic [4:0] c_legal_codes [0:NUM_PHASES-1] = '{
        5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
        5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000
    };

    localparam logic [3:0] c_last_phase = 4'(NUM_PHASES - 1);

    // Successor phase, wrapping 9 -> 0.
    function automatic logic [3:0] next_phase(input logic [3:0] idx);
        next_phase = (idx == c_last_phase) ? 4'd0 : idx + 4'd1;
    endfunction

    // One-hot vector with bit idx set.
    function automatic logic [NUM_PHASES-1:0] onehot_of(input logic [3:0] idx);
        onehot_of = {{(NUM_PHASES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_code_lookup.sv
`default_nettype none
// ============================================================================
// Module      : johnson_code_lookup
// Description : Purely combinational decode of a 5-bit twisted-ring code into
//               a phase index and a legality flag. Illegal codes yield idx 0.
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_code_lookup
    import johnson_phase_decoder_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [3:0] o_idx,
    output logic       o_legal
);

    // Match the code against every table entry; at most one can hit.
    always_comb begin
        o_idx   = 4'd0;
        o_legal = 1'b0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (i_code == c_legal_codes[i]) begin
                o_idx   = 4'(i);
                o_legal = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/johnson_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module      : johnson_phase_decoder
// Description : Decodes a 5-stage Johnson counter state into a phase index and
//               one-hot phase, tracks lock on the legal step sequence, flags
//               illegal codes and illegal steps, and counts 9->0 revolutions.
//               All outputs are registered (1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_phase_decoder
    import johnson_phase_decoder_pkg::*;
#(
    parameter int REV_W = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [4:0]            code,
    input  logic                  sync_clr,
    output logic                  phase_valid,
    output logic [3:0]            phase_idx,
    output logic [NUM_PHASES-1:0] phase_onehot,
    output logic                  code_err,
    output logic                  step_err,
    output logic                  err_sticky,
    output logic                  locked,
    output logic [REV_W-1:0]      rev_count
);

    jpd_state_t r_state;
    logic [3:0] r_prev_idx;

    logic [3:0] w_idx;
    logic       w_legal;
    logic       w_step_ok;
    logic       w_is_locked;
    logic       w_rev_step;
    logic       w_err_now;

    johnson_code_lookup u_lookup (
        .i_code  (code),
        .o_idx   (w_idx),
        .o_legal (w_legal)
    );

    // A hold on the same phase or a single forward step keeps lock.
    assign w_step_ok   = (w_idx == r_prev_idx) || (w_idx == next_phase(r_prev_idx));
    assign w_is_locked = (r_state == LOCKED);

    // Revolution: legal 9 -> 0 step while already locked, so the code that
    // first acquires lock can never count.
    assign w_rev_step = in_valid && w_legal && w_is_locked &&
                        (r_prev_idx == c_last_phase) && (w_idx == 4'd0);

    // Any error pulse that will be raised at this edge.
    assign w_err_now = in_valid && (!w_legal || (w_is_locked && !w_step_ok));

    // Lock FSM, registered phase outputs, error flags and revolution counter.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state      <= UNLOCKED;
            r_prev_idx   <= 4'd0;
            phase_valid  <= 1'b0;
            phase_idx    <= 4'd0;
            phase_onehot <= onehot_of(4'd0);
            code_err     <= 1'b0;
            step_err     <= 1'b0;
            err_sticky   <= 1'b0;
            locked       <= 1'b0;
            rev_count    <= '0;
        end else begin
            code_err    <= 1'b0;
            step_err    <= 1'b0;
            phase_valid <= in_valid && w_legal;

            if (in_valid) begin
                if (w_legal) begin
                    phase_idx    <= w_idx;
                    phase_onehot <= onehot_of(w_idx);
                end

                case (r_state)
                    UNLOCKED: begin
                        if (w_legal) begin
                            r_state    <= LOCKED;
                            r_prev_idx <= w_idx;
                            locked     <= 1'b1;
                        end else begin
                            code_err <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!w_legal) begin
                            code_err <= 1'b1;
                            r_state  <= UNLOCKED;
                            locked   <= 1'b0;
                        end else if (w_step_ok) begin
                            r_prev_idx <= w_idx;
                        end else begin
                            step_err <= 1'b1;
                            r_state  <= UNLOCKED;
                            locked   <= 1'b0;
                        end
                    end
                endcase
            end

            // Synchronous clear beats a coincident revolution.
            if (sync_clr) begin
                rev_count <= '0;
            end else if (w_rev_step) begin
                rev_count <= rev_count + 1'b1;
            end

            // A coincident error beats synchronous clear.
            if (w_err_now) begin
                err_sticky <= 1'b1;
            end else if (sync_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
